// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle core: accepts one load/store, waits
// LATENCY cycles, performs a little-endian byte/half/word access, pulses ready.

module data_mem_lane #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, nextState;
  logic              access;
  logic [AW+1:0]     addrQ;
  logic [31:0]       wdataQ;
  logic [1:0]        sizeQ;
  logic              unsQ, rdQ, wrQ, errQ;
  logic [3:0]        cnt;
  logic              reqErr;
  logic [NUM_LANES-1:0]      laneSel, laneWe;
  logic [NUM_LANES-1:0][7:0] wAligned, rdWord;
  logic [7:0]        ldByte;
  logic [15:0]       ldHalf;
  logic [31:0]       ldData;
  logic              unusedAddrHi;

  // Address bits above the array are deliberately ignored (wrap-around).
  assign unusedAddrHi = ^addr[31:AW+2];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nextState;

  always_comb begin
    nextState = state;
    access    = 1'b0;
    case (state)
      IDLE: if (req_rd || req_wr) nextState = WAIT;
      WAIT: if (cnt == 4'd0) begin
        nextState = DONE;
        access    = 1'b1;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addrQ  <= '0;
      wdataQ <= '0;
      sizeQ  <= '0;
      unsQ   <= 1'b0;
      rdQ    <= 1'b0;
      wrQ    <= 1'b0;
      cnt    <= '0;
      errQ   <= 1'b0;
      rdata  <= '0;
    end else begin
      if (state == IDLE && (req_rd || req_wr)) begin
        addrQ  <= addr[AW+1:0];
        wdataQ <= wdata;
        sizeQ  <= size;
        unsQ   <= unsigned_ld;
        rdQ    <= req_rd;
        wrQ    <= req_wr;
        cnt    <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        errQ <= reqErr;
        if (reqErr)   rdata <= '0;
        else if (rdQ) rdata <= ldData;
      end
    end

  assign reqErr = (rdQ && wrQ) || (sizeQ == 2'd3) ||
                  (sizeQ == 2'd1 && addrQ[0]) ||
                  (sizeQ == 2'd2 && addrQ[1:0] != 2'd0);

  // Store data is replicated so every lane sees its byte of a right-aligned value.
  always_comb begin
    case (sizeQ)
      2'd0:    wAligned = {4{wdataQ[7:0]}};
      2'd1:    wAligned = {2{wdataQ[15:0]}};
      default: wAligned = wdataQ;
    endcase
    for (int l = 0; l < NUM_LANES; l++) begin
      case (sizeQ)
        2'd0:    laneSel[l] = (addrQ[1:0] == 2'(l));
        2'd1:    laneSel[l] = (addrQ[1] == 1'(l / 2));
        default: laneSel[l] = 1'b1;
      endcase
      laneWe[l] = access && wrQ && !reqErr && laneSel[l];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    data_mem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) uLane (
      .clk  (clk),
      .we   (laneWe[g]),
      .idx  (addrQ[AW+1:2]),
      .wbyte(wAligned[g]),
      .rbyte(rdWord[g])
    );
  end

  always_comb begin
    ldByte = rdWord[addrQ[1:0]];
    ldHalf = addrQ[1] ? {rdWord[3], rdWord[2]} : {rdWord[1], rdWord[0]};
    case (sizeQ)
      2'd0:    ldData = unsQ ? {24'd0, ldByte} : {{24{ldByte[7]}}, ldByte};
      2'd1:    ldData = unsQ ? {16'd0, ldHalf} : {{16{ldHalf[15]}}, ldHalf};
      default: ldData = rdWord;
    endcase
  end

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);
  assign err   = ready && errQ;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 0, 15) sharing data inputs,
// each with its own request strobes.

module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  reqRd = '0, reqWr = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        unsignedLd = 1'b0;
  logic [2:0]  busyV, readyV, errV;
  logic [31:0] rdataV [3];

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    data_mem_responder #(
      .DEPTH_WORDS(64),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 15))
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (reqRd[g]),
      .req_wr     (reqWr[g]),
      .addr       (addr),
      .wdata      (wdata),
      .size       (size),
      .unsigned_ld(unsignedLd),
      .busy       (busyV[g]),
      .ready      (readyV[g]),
      .rdata      (rdataV[g]),
      .err        (errV[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; returns edges from acceptance to ready and busy cycle count.
  task automatic doOp(input int k, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                      output int lat, output int busyCyc, output logic [31:0] rdat,
                      output logic e);
    @(negedge clk);
    reqRd[k] = rd; reqWr[k] = wr; addr = a; wdata = wd; size = sz; unsignedLd = uns;
    @(posedge clk); #1;
    reqRd[k] = 1'b0; reqWr[k] = 1'b0;
    addr = $urandom; wdata = $urandom; size = 2'($urandom); unsignedLd = 1'($urandom);
    lat = -1; busyCyc = 0; rdat = 'x; e = 1'bx;
    for (int n = 0; n < 40; n++) begin
      if (busyV[k]) busyCyc++;
      if (readyV[k]) begin
        lat = n; rdat = rdataV[k]; e = errV[k];
      end
      if (!busyV[k]) break;
      @(posedge clk); #1;
    end
  endtask

  int lat, bc, rdyCnt;
  logic [31:0] rd;
  logic e;

  initial begin
    #12;
    chk("rst_busy",  32'(busyV),  32'h0);
    chk("rst_ready", 32'(readyV), 32'h0);
    chk("rst_err",   32'(errV),   32'h0);
    chk("rst_rdata", rdataV[0],   32'h0);
    @(negedge clk); rst = 1'b1;

    // word round trip
    doOp(0, 0, 1, 32'h10, 32'h11223344, 2, 0, lat, bc, rd, e);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(e), 32'd0);
    doOp(0, 1, 0, 32'h10, 32'h0, 2, 0, lat, bc, rd, e);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_busy", 32'(bc), 32'd3);
    chk("lw_data", rd, 32'h11223344);
    chk("lw_err", 32'(e), 32'd0);

    // sub-word stores and loads
    doOp(0, 0, 1, 32'h12, 32'h555555AB, 0, 0, lat, bc, rd, e);
    chk("sb_rdata_kept", rd, 32'h11223344);
    doOp(0, 1, 0, 32'h12, 32'h0, 0, 0, lat, bc, rd, e);
    chk("lb", rd, 32'hFFFFFFAB);
    doOp(0, 1, 0, 32'h12, 32'h0, 0, 1, lat, bc, rd, e);
    chk("lbu", rd, 32'h000000AB);
    doOp(0, 1, 0, 32'h12, 32'h0, 1, 0, lat, bc, rd, e);
    chk("lh_hi", rd, 32'h000011AB);
    doOp(0, 1, 0, 32'h10, 32'h0, 2, 1, lat, bc, rd, e);
    chk("lw_after_sb", rd, 32'h11AB3344);
    doOp(0, 0, 1, 32'h10, 32'h12348001, 1, 0, lat, bc, rd, e);
    chk("sh_rdata_kept", rd, 32'h11AB3344);
    chk("sh_err", 32'(e), 32'd0);
    doOp(0, 1, 0, 32'h10, 32'h0, 1, 0, lat, bc, rd, e);
    chk("lh_lo", rd, 32'hFFFF8001);
    doOp(0, 1, 0, 32'h10, 32'h0, 1, 1, lat, bc, rd, e);
    chk("lhu_lo", rd, 32'h00008001);
    doOp(0, 1, 0, 32'h13, 32'h0, 0, 0, lat, bc, rd, e);
    chk("lb_lane3", rd, 32'h00000011);

    // error cases
    doOp(0, 1, 0, 32'h02, 32'h0, 2, 0, lat, bc, rd, e);
    chk("lw_misal_err", 32'(e), 32'd1);
    chk("lw_misal_data", rd, 32'h0);
    chk("lw_misal_lat", 32'(lat), 32'd2);
    doOp(0, 0, 1, 32'h11, 32'h0000FFFF, 1, 0, lat, bc, rd, e);
    chk("sh_misal_err", 32'(e), 32'd1);
    doOp(0, 1, 1, 32'h10, 32'h0, 2, 0, lat, bc, rd, e);
    chk("rdwr_err", 32'(e), 32'd1);
    chk("rdwr_data", rd, 32'h0);
    doOp(0, 1, 0, 32'h10, 32'h0, 3, 0, lat, bc, rd, e);
    chk("size3_err", 32'(e), 32'd1);
    doOp(0, 1, 0, 32'h10, 32'h0, 2, 0, lat, bc, rd, e);
    chk("mem_unchanged", rd, 32'h11AB8001);
    chk("ok_err_clear", 32'(e), 32'd0);

    // reset during WAIT discards the pending store
    doOp(0, 0, 1, 32'h20, 32'h01234567, 2, 0, lat, bc, rd, e);
    @(negedge clk);
    reqWr[0] = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF; size = 2'd2;
    @(posedge clk); #1;
    reqWr[0] = 1'b0;
    chk("pre_rst_busy", 32'(busyV[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busyV[0]), 32'd0);
    rdyCnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (readyV[0]) rdyCnt++;
    end
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (readyV[0]) rdyCnt++;
    end
    chk("rst_no_ready", 32'(rdyCnt), 32'd0);
    doOp(0, 1, 0, 32'h20, 32'h0, 2, 0, lat, bc, rd, e);
    chk("rst_old_value", rd, 32'h01234567);

    // request while busy is ignored
    @(negedge clk);
    reqRd[0] = 1'b1; addr = 32'h10; size = 2'd2;
    @(posedge clk); #1;
    reqRd[0] = 1'b0;
    rdyCnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (readyV[0]) rdyCnt++;
      reqRd[0] = (n == 0);
    end
    reqRd[0] = 1'b0;
    chk("busy_one_ready", 32'(rdyCnt), 32'd1);

    // address wrap
    doOp(0, 0, 1, 32'h100, 32'hCAFEF00D, 2, 0, lat, bc, rd, e);
    doOp(0, 1, 0, 32'h000, 32'h0, 2, 0, lat, bc, rd, e);
    chk("wrap", rd, 32'hCAFEF00D);

    // latency sweep
    doOp(1, 0, 1, 32'h40, 32'h5A5AA5A5, 2, 0, lat, bc, rd, e);
    chk("lat0_sw_lat", 32'(lat), 32'd1);
    doOp(1, 1, 0, 32'h40, 32'h0, 2, 0, lat, bc, rd, e);
    chk("lat0_lat", 32'(lat), 32'd1);
    chk("lat0_busy", 32'(bc), 32'd2);
    chk("lat0_data", rd, 32'h5A5AA5A5);
    doOp(2, 0, 1, 32'h44, 32'h0F0F1234, 2, 0, lat, bc, rd, e);
    chk("lat15_sw_lat", 32'(lat), 32'd16);
    doOp(2, 1, 0, 32'h46, 32'h0, 1, 0, lat, bc, rd, e);
    chk("lat15_lat", 32'(lat), 32'd16);
    chk("lat15_busy", 32'(bc), 32'd17);
    chk("lat15_data", rd, 32'h00000F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
